// File: rtl/regfile_pkg.sv
// Shared widths and types for the register file and its scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-through reads, writeback-cycle issue).
package regfile_pkg;

  localparam int unsigned LEN_REGNO = 5;
  localparam int unsigned LEN_REG   = 32;
  localparam int unsigned NUM_REG   = 2 ** LEN_REGNO;

  typedef logic [LEN_REGNO-1:0] regno_t;
  typedef logic [LEN_REG-1:0]   reg_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/issue and writeback signal bundle for the register file.
// master = pipeline side driving requests, slave = register file.
interface regfile_if;
  import regfile_pkg::*;

  regno_t rs_regno;
  regno_t rt_regno;
  logic   rs_use;
  logic   rt_use;
  reg_t   rs_data;
  reg_t   rt_data;
  logic   issue_valid;
  logic   issue_has_rd;
  regno_t issue_rd_regno;
  logic   stall;
  logic   is_wb;
  regno_t wb_regno;
  reg_t   wb_data;

  modport master (
    output rs_regno, rt_regno, rs_use, rt_use,
    output issue_valid, issue_has_rd, issue_rd_regno,
    output is_wb, wb_regno, wb_data,
    input  rs_data, rt_data, stall
  );

  modport slave (
    input  rs_regno, rt_regno, rs_use, rt_use,
    input  issue_valid, issue_has_rd, issue_rd_regno,
    input  is_wb, wb_regno, wb_data,
    output rs_data, rt_data, stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight producers and RAW/WAW stall generation.
// REGFILE_BYPASS_EN lets a consumer issue in its producer's writeback cycle.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  regno_t rs_regno,
  input  regno_t rt_regno,
  input  logic   rs_use,
  input  logic   rt_use,
  input  logic   issue_valid,
  input  logic   issue_has_rd,
  input  regno_t issue_rd_regno,
  input  logic   is_wb,
  input  regno_t wb_regno,
  output logic   stall
);

  logic [NUM_REG-1:0] pending_q;
  logic [NUM_REG-1:0] pending_d;
  logic [NUM_REG-1:0] busy;

  always_comb begin
    busy = pending_q;
`ifdef REGFILE_BYPASS_EN
    if (is_wb) busy[wb_regno] = 1'b0;
`endif
  end

  // WAW looks at raw pending bits: a destination is never bypassed.
  assign stall = issue_valid & ((rs_use & busy[rs_regno]) |
                                (rt_use & busy[rt_regno]) |
                                (issue_has_rd & pending_q[issue_rd_regno]));

  // Clear before set so a same-cycle issue to the written register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (is_wb) pending_d[wb_regno] = 1'b0;
    if (issue_valid && !stall && issue_has_rd) pending_d[issue_rd_regno] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural register file: one write port, two combinational read ports, hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile
  import regfile_pkg::*;
(
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  reg_t regs_q [NUM_REG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
    end else if (bus.is_wb) begin
      regs_q[bus.wb_regno] <= bus.wb_data;
    end
  end

  always_comb begin
    bus.rs_data = regs_q[bus.rs_regno];
    bus.rt_data = regs_q[bus.rt_regno];
`ifdef REGFILE_BYPASS_EN
    if (bus.is_wb && (bus.wb_regno == bus.rs_regno)) bus.rs_data = bus.wb_data;
    if (bus.is_wb && (bus.wb_regno == bus.rt_regno)) bus.rt_data = bus.wb_data;
`endif
  end

  regfile_scoreboard u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .rs_regno       (bus.rs_regno),
    .rt_regno       (bus.rt_regno),
    .rs_use         (bus.rs_use),
    .rt_use         (bus.rt_use),
    .issue_valid    (bus.issue_valid),
    .issue_has_rd   (bus.issue_has_rd),
    .issue_rd_regno (bus.issue_rd_regno),
    .is_wb          (bus.is_wb),
    .wb_regno       (bus.wb_regno),
    .stall          (bus.stall)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed hazard scenarios plus randomized traffic
// checked against an array-based model of registers and in-flight producers.
module tb_regfile;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  regfile_if bus ();

  regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  reg_t m_regs [NUM_REG];
  bit   m_pend [NUM_REG];

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  function automatic reg_t exp_read(regno_t r);
    if (Bypass && bus.is_wb && bus.wb_regno == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic bit exp_busy(regno_t r);
    if (Bypass && bus.is_wb && bus.wb_regno == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit exp_stall();
    if (!bus.issue_valid) return 1'b0;
    return (bus.rs_use && exp_busy(bus.rs_regno)) || (bus.rt_use && exp_busy(bus.rt_regno)) ||
           (bus.issue_has_rd && m_pend[bus.issue_rd_regno]);
  endfunction

  task automatic idle();
    bus.rs_regno = '0; bus.rt_regno = '0; bus.rs_use = 1'b0; bus.rt_use = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0; bus.issue_rd_regno = '0;
    bus.is_wb = 1'b0; bus.wb_regno = '0; bus.wb_data = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Advance one clock; the model commits what the inputs imply at this edge.
  task automatic tick();
    bit stl;
    @(posedge clk);
    stl = exp_stall();
    if (bus.is_wb) begin
      m_regs[bus.wb_regno] = bus.wb_data;
      m_pend[bus.wb_regno] = 1'b0;
    end
    if (bus.issue_valid && !stl && bus.issue_has_rd) m_pend[bus.issue_rd_regno] = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue_rd(regno_t rd);
    idle();
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd_regno = rd;
  endtask

  task automatic write(regno_t r, reg_t d);
    idle();
    bus.is_wb = 1'b1; bus.wb_regno = r; bus.wb_data = d;
  endtask

  task automatic test_reset();
    write(5'd3, 32'hCAFE_F00D); tick();
    issue_rd(5'd3); tick();
    issue_rd(5'd3); #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL reset_pre_stall: got %b expected 1", bus.stall);
    else n_pass++;
    #2 rst = 1'b0; model_reset(); #1;
    bus.rs_regno = 5'd3; bus.rt_regno = 5'd3; #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.stall);
    else n_pass++;
    n_total++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0)
      $display("FAIL reset_data: got %h/%h expected 0/0", bus.rs_data, bus.rt_data);
    else n_pass++;
    idle();
    @(negedge clk); rst = 1'b1; @(negedge clk);
    issue_rd(5'd3); #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL reset_post_stall: got %b expected 0", bus.stall);
    else n_pass++;
    tick();
    write(5'd3, 32'h0000_0055); tick();
  endtask

  task automatic test_write_read();
    write(5'd5, 32'hDEAD_BEEF); tick();
    idle(); bus.issue_valid = 1'b1; bus.rs_use = 1'b1; bus.rs_regno = 5'd5; #1;
    n_total++;
    if (bus.rs_data !== 32'hDEAD_BEEF)
      $display("FAIL wr_data: got %h expected deadbeef", bus.rs_data);
    else n_pass++;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL wr_stall: got %b expected 0", bus.stall);
    else n_pass++;
    tick();
  endtask

  task automatic test_raw();
    issue_rd(5'd7); tick();
    idle(); bus.issue_valid = 1'b1; bus.rs_use = 1'b1; bus.rs_regno = 5'd7; #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL raw_stall: got %b expected 1", bus.stall);
    else n_pass++;
    tick();
    bus.is_wb = 1'b1; bus.wb_regno = 5'd7; bus.wb_data = 32'h7777_0001; #1;
    n_total++;
    if (bus.stall !== !Bypass) $display("FAIL raw_wb_stall: got %b expected %b", bus.stall, !Bypass);
    else n_pass++;
    n_total++;
    if (Bypass && bus.rs_data !== 32'h7777_0001)
      $display("FAIL raw_bypass_data: got %h expected 77770001", bus.rs_data);
    else if (!Bypass && bus.rs_data !== 32'h0)
      $display("FAIL raw_old_data: got %h expected 0", bus.rs_data);
    else n_pass++;
    tick();
    bus.is_wb = 1'b0; #1;
    n_total++;
    if (bus.stall !== 1'b0 || bus.rs_data !== 32'h7777_0001)
      $display("FAIL raw_after: got %b/%h expected 0/77770001", bus.stall, bus.rs_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_waw();
    issue_rd(5'd2); tick();
    issue_rd(5'd2); bus.is_wb = 1'b1; bus.wb_regno = 5'd2; bus.wb_data = 32'h22; #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL waw_stall: got %b expected 1", bus.stall);
    else n_pass++;
    tick();
    bus.is_wb = 1'b0; #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL waw_release: got %b expected 0", bus.stall);
    else n_pass++;
    tick();
    idle(); bus.issue_valid = 1'b1; bus.rt_use = 1'b1; bus.rt_regno = 5'd2; #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL waw_reset_pending: got %b expected 1", bus.stall);
    else n_pass++;
    write(5'd2, 32'h23); tick();
  endtask

  task automatic test_set_clear();
    issue_rd(5'd4); bus.is_wb = 1'b1; bus.wb_regno = 5'd4; bus.wb_data = 32'h44; #1;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL sc_accept: got %b expected 0", bus.stall);
    else n_pass++;
    tick();
    issue_rd(5'd4); #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL sc_set_wins: got %b expected 1", bus.stall);
    else n_pass++;
    write(5'd4, 32'h45); tick();
  endtask

  task automatic test_dual_port();
    write(5'd9, 32'h1234); tick();
    idle(); bus.rs_regno = 5'd9; bus.rt_regno = 5'd9; #1;
    n_total++;
    if (bus.rs_data !== 32'h1234 || bus.rt_data !== 32'h1234)
      $display("FAIL dual_same: got %h/%h expected 1234/1234", bus.rs_data, bus.rt_data);
    else n_pass++;
    write(5'd0, 32'h1); tick();
    idle(); #1;
    n_total++;
    if (bus.rs_data !== 32'h1 || bus.rt_data !== 32'h1)
      $display("FAIL reg0: got %h/%h expected 1/1", bus.rs_data, bus.rt_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      bus.rs_regno       = regno_t'($urandom_range(0, 7));
      bus.rt_regno       = regno_t'($urandom_range(0, 7));
      bus.rs_use         = 1'($urandom_range(0, 1));
      bus.rt_use         = 1'($urandom_range(0, 1));
      bus.issue_valid    = ($urandom_range(0, 3) != 0);
      bus.issue_has_rd   = 1'($urandom_range(0, 1));
      bus.issue_rd_regno = regno_t'($urandom_range(0, 7));
      bus.is_wb          = ($urandom_range(0, 9) < 4);
      bus.wb_regno       = regno_t'($urandom_range(0, 7));
      bus.wb_data        = $urandom;
      #1;
      n_total++;
      if (bus.stall !== exp_stall())
        $display("FAIL rnd_stall[%0d]: got %b expected %b", c, bus.stall, exp_stall());
      else n_pass++;
      n_total++;
      if (bus.rs_data !== exp_read(bus.rs_regno))
        $display("FAIL rnd_rs[%0d]: got %h expected %h", c, bus.rs_data, exp_read(bus.rs_regno));
      else n_pass++;
      n_total++;
      if (bus.rt_data !== exp_read(bus.rt_regno))
        $display("FAIL rnd_rt[%0d]: got %h expected %h", c, bus.rt_data, exp_read(bus.rt_regno));
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_set_clear();
    test_dual_port();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
